// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the decode-stage issue scoreboard.
package scoreboard_pkg;
   localparam int NUM_REGS = 32;
   localparam logic [4:0] REG_X0 = 5'd0;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      DRAIN = 2'd2
   } sb_state_e;
endpackage

// File: rtl/sb_pending_cnt.sv
// Per-register pending-writer counter; simultaneous inc and dec cancel out.
module sb_pending_cnt #(
   parameter int CNT_W = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   output logic sat,
   output logic zero,
   output logic one
);
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (inc && !dec && !sat)
         cnt <= cnt + CNT_W'(1);
      else if (dec && !inc && !zero)
         cnt <= cnt - CNT_W'(1);
   end

   assign sat  = &cnt;
   assign zero = (cnt == '0);
   assign one  = (cnt == CNT_W'(1));
endmodule

// File: rtl/decode_scoreboard.sv
// Decode issue controller: RAW/WAW, capacity and fence gating with RUN/STALL/DRAIN FSM.
// Optional SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback clear hazard/full terms.
module decode_scoreboard
   import scoreboard_pkg::*;
#(
   parameter int MAX_INFLIGHT = 4,
   parameter int CNT_W        = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic [4:0] id_rd_i,
   input  logic       id_uses_rs1_i,
   input  logic       id_uses_rs2_i,
   input  logic       id_writes_rd_i,
   input  logic       id_fence_i,
   input  logic       flush_i,
   input  logic       wb_valid_i,
   input  logic [4:0] wb_rd_i,
   output logic       id_ready_o,
   output logic       issue_o,
   output logic [3:0] outstanding_o,
   output logic [1:0] state_o,
   output logic       err_o
);
   sb_state_e state, state_nxt;
   logic [3:0] outstanding, out_eff;
   logic [NUM_REGS-1:0] sat_v, zero_v, busy_v;
   logic [NUM_REGS-1:1] inc_v, dec_v, one_v;
   logic rd_nz, wb_nz, wb_err, dec_ok, issue_wr;
   logic hazard, full, sat, fence_wait, block;

   // x0 is never tracked: always idle, never saturated
   assign zero_v[0] = 1'b1;
   assign sat_v[0]  = 1'b0;

   genvar r;
   generate
      for (r = 1; r < NUM_REGS; r++) begin : g_reg
         sb_pending_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (inc_v[r]),
            .dec  (dec_v[r]),
            .sat  (sat_v[r]),
            .zero (zero_v[r]),
            .one  (one_v[r])
         );
      end
   endgenerate

   assign rd_nz  = id_writes_rd_i & (id_rd_i != REG_X0);
   assign wb_nz  = wb_valid_i & (wb_rd_i != REG_X0);
   assign wb_err = wb_nz & (zero_v[wb_rd_i] | (outstanding == 4'd0));
   assign dec_ok = wb_nz & ~wb_err;

   always_comb begin
      inc_v  = '0;
      dec_v  = '0;
      busy_v = ~zero_v;
      for (int i = 1; i < NUM_REGS; i++) begin
         inc_v[i] = issue_wr & (id_rd_i == 5'(i));
         dec_v[i] = dec_ok & (wb_rd_i == 5'(i));
`ifdef SCOREBOARD_WB_BYPASS_EN
         // last pending writer retiring now: value is on the write-through path
         if (one_v[i] && dec_v[i])
            busy_v[i] = 1'b0;
`endif
      end
   end

`ifdef SCOREBOARD_WB_BYPASS_EN
   assign out_eff = outstanding - {3'b0, dec_ok};
`else
   assign out_eff = outstanding;
`endif

   assign hazard     = (id_uses_rs1_i & busy_v[id_rs1_i]) | (id_uses_rs2_i & busy_v[id_rs2_i]);
   assign full       = (out_eff == 4'(MAX_INFLIGHT)) & rd_nz;
   assign sat        = rd_nz & sat_v[id_rd_i];
   assign fence_wait = id_fence_i & (outstanding != 4'd0);
   assign block      = hazard | full | sat;

   assign id_ready_o = (state != DRAIN) & ~block & ~fence_wait;
   assign issue_o    = id_valid_i & id_ready_o & ~flush_i;
   assign issue_wr   = issue_o & rd_nz;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding <= 4'd0;
         err_o       <= 1'b0;
         state       <= RUN;
      end else begin
         outstanding <= outstanding + {3'b0, issue_wr} - {3'b0, dec_ok};
         if (wb_err)
            err_o <= 1'b1;
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:
            if (id_valid_i && !flush_i) begin
               if (fence_wait)
                  state_nxt = DRAIN;
               else if (block)
                  state_nxt = STALL;
            end
         STALL:
            if (!id_valid_i || flush_i || !block)
               state_nxt = RUN;
         DRAIN:
            if (flush_i || (outstanding == 4'd0))
               state_nxt = RUN;
         default:
            state_nxt = RUN;
      endcase
   end

   assign outstanding_o = outstanding;
   assign state_o       = state;
endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench: expectations queued with each stimulus step, drained when outputs settle.
module tb_decode_scoreboard;
   import scoreboard_pkg::*;

   localparam int S_RDY = 0, S_ISS = 1, S_OUT = 2, S_ST = 3, S_ERR = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid_i = 0, id_uses_rs1_i = 0, id_uses_rs2_i = 0;
   logic       id_writes_rd_i = 0, id_fence_i = 0, flush_i = 0, wb_valid_i = 0;
   logic [4:0] id_rs1_i = 0, id_rs2_i = 0, id_rd_i = 0, wb_rd_i = 0;
   logic       id_ready_o, issue_o, err_o;
   logic [3:0] outstanding_o;
   logic [1:0] state_o;

   typedef struct {
      string      tag;
      int         sel;
      logic [3:0] exp;
   } exp_t;

   exp_t q[$];
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   decode_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .id_valid_i     (id_valid_i),
      .id_rs1_i       (id_rs1_i),
      .id_rs2_i       (id_rs2_i),
      .id_rd_i        (id_rd_i),
      .id_uses_rs1_i  (id_uses_rs1_i),
      .id_uses_rs2_i  (id_uses_rs2_i),
      .id_writes_rd_i (id_writes_rd_i),
      .id_fence_i     (id_fence_i),
      .flush_i        (flush_i),
      .wb_valid_i     (wb_valid_i),
      .wb_rd_i        (wb_rd_i),
      .id_ready_o     (id_ready_o),
      .issue_o        (issue_o),
      .outstanding_o  (outstanding_o),
      .state_o        (state_o),
      .err_o          (err_o)
   );

   function automatic logic [3:0] observe(input int sel);
      case (sel)
         S_RDY:   return {3'b0, id_ready_o};
         S_ISS:   return {3'b0, issue_o};
         S_OUT:   return outstanding_o;
         S_ST:    return {2'b0, state_o};
         default: return {3'b0, err_o};
      endcase
   endfunction

   task automatic want(input string tag, input int sel, input logic [3:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = v;
      q.push_back(e);
   endtask

   task automatic check();
      exp_t e;
      logic [3:0] obs;
      #3;
      while (q.size() > 0) begin
         e   = q.pop_front();
         obs = observe(e.sel);
         n_cmp++;
         assert (obs === e.exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
         end
      end
   endtask

   // next cycle with decode idle and no writeback unless the step drives them
   task automatic step();
      @(posedge clk);
      #1;
      id_valid_i = 0; id_fence_i = 0; flush_i = 0;
      id_uses_rs1_i = 0; id_uses_rs2_i = 0; id_writes_rd_i = 0;
      wb_valid_i = 0; wb_rd_i = 0;
   endtask

   task automatic instr(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic wr, input logic fence);
      id_valid_i = 1; id_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2;
      id_uses_rs1_i = u1; id_uses_rs2_i = u2; id_writes_rd_i = wr; id_fence_i = fence;
   endtask

   task automatic wb(input logic [4:0] rd);
      wb_valid_i = 1; wb_rd_i = rd;
   endtask

   initial begin
      #1;
      want("rst_ready", S_RDY, 1); want("rst_issue", S_ISS, 0); want("rst_out", S_OUT, 0);
      want("rst_state", S_ST, 0); want("rst_err", S_ERR, 0);
      check();
      step(); rst = 0;

      // RAW hazard on x5
      step(); instr(5, 1, 2, 1, 1, 1, 0);
      want("raw_first_issue", S_ISS, 1); want("raw_first_out", S_OUT, 0);
      check();
      step(); instr(6, 5, 1, 1, 1, 1, 0);
      want("raw_dep_ready", S_RDY, 0); want("raw_dep_out", S_OUT, 1); want("raw_dep_state", S_ST, 0);
      check();
      step(); instr(6, 5, 1, 1, 1, 1, 0); wb(5);
      want("raw_stall_state", S_ST, 1); want("raw_wb_ready", S_RDY, 0);
      check();
      step(); instr(6, 5, 1, 1, 1, 1, 0);
      want("raw_after_wb_ready", S_RDY, 1); want("raw_after_wb_issue", S_ISS, 1);
      want("raw_after_wb_out", S_OUT, 0); want("raw_after_wb_state", S_ST, 1);
      check();
      step(); wb(6);
      want("raw_back_run", S_ST, 0); want("raw_out_x6", S_OUT, 1);
      check();
      step();
      want("raw_drained", S_OUT, 0); want("raw_err", S_ERR, 0);
      check();

      // capacity limit
      for (int k = 1; k <= 4; k++) begin
         step(); instr(5'(k), 0, 0, 0, 0, 1, 0);
         want("fill_issue", S_ISS, 1); want("fill_out", S_OUT, 4'(k - 1));
         check();
      end
      step(); instr(7, 0, 0, 0, 0, 1, 0);
      want("full_ready", S_RDY, 0); want("full_out", S_OUT, 4); want("full_issue", S_ISS, 0);
      check();
      step(); instr(7, 0, 0, 0, 0, 1, 0); wb(1);
      want("full_stall_state", S_ST, 1); want("full_wb_ready", S_RDY, 0);
      check();
      step(); instr(7, 0, 0, 0, 0, 1, 0);
      want("full_after_wb_ready", S_RDY, 1); want("full_after_wb_out", S_OUT, 3);
      want("full_after_wb_issue", S_ISS, 1);
      check();
      step(); wb(2);
      want("full_refill_out", S_OUT, 4);
      check();
      step(); wb(3);
      want("full_wb3_out", S_OUT, 3);
      check();

      // fence drain with two outstanding (x4, x7)
      step(); instr(0, 0, 0, 0, 0, 0, 1);
      want("fence_ready", S_RDY, 0); want("fence_out", S_OUT, 2); want("fence_state_run", S_ST, 0);
      check();
      step(); instr(0, 0, 0, 0, 0, 0, 1); wb(4);
      want("drain_state", S_ST, 2); want("drain_ready", S_RDY, 0);
      check();
      step(); instr(0, 0, 0, 0, 0, 0, 1); wb(7);
      want("drain_out1", S_OUT, 1); want("drain_state1", S_ST, 2);
      check();
      step(); instr(0, 0, 0, 0, 0, 0, 1);
      want("drain_out0", S_OUT, 0); want("drain_hold_ready", S_RDY, 0); want("drain_hold_state", S_ST, 2);
      check();
      step(); instr(0, 0, 0, 0, 0, 0, 1);
      want("fence_run_state", S_ST, 0); want("fence_issue", S_ISS, 1);
      check();

      // same-cycle issue and writeback on x9
      step(); instr(9, 0, 0, 0, 0, 1, 0);
      want("x9_issue", S_ISS, 1);
      check();
      step(); instr(9, 0, 0, 0, 0, 1, 0); wb(9);
      want("x9_same_issue", S_ISS, 1); want("x9_same_out", S_OUT, 1);
      check();
      step();
      want("x9_net_out", S_OUT, 1);
      check();
      step(); instr(0, 9, 0, 1, 0, 0, 0); wb(9);
      want("x9_pend1_ready", S_RDY, 0);
      check();
      step(); instr(0, 9, 0, 1, 0, 0, 0);
      want("x9_cleared_ready", S_RDY, 1); want("x9_cleared_out", S_OUT, 0);
      check();

      // x0 is untracked
      step(); instr(0, 0, 0, 1, 1, 1, 0);
      want("x0_ready", S_RDY, 1); want("x0_issue", S_ISS, 1);
      check();
      step(); wb(0);
      want("x0_no_count", S_OUT, 0);
      check();
      step();
      want("x0_wb_no_err", S_ERR, 0);
      check();

      // pending counter saturation on x10
      for (int k = 0; k < 3; k++) begin
         step(); instr(10, 0, 0, 0, 0, 1, 0);
         want("sat_fill_issue", S_ISS, 1);
         check();
      end
      step(); instr(10, 0, 0, 0, 0, 1, 0);
      want("sat_ready", S_RDY, 0); want("sat_out", S_OUT, 3);
      check();
      for (int k = 0; k < 3; k++) begin
         step(); wb(10);
         want("sat_drain_out", S_OUT, 4'(3 - k));
         check();
      end
      step();
      want("sat_empty_out", S_OUT, 0); want("sat_err", S_ERR, 0);
      check();

      // flush holds RUN, and releases DRAIN
      step(); instr(14, 0, 0, 0, 0, 1, 0);
      want("fl_issue", S_ISS, 1);
      check();
      step(); instr(0, 0, 0, 0, 0, 0, 1); flush_i = 1;
      want("fl_fence_issue", S_ISS, 0);
      check();
      step(); instr(0, 0, 0, 0, 0, 0, 1);
      want("fl_still_run", S_ST, 0);
      check();
      step(); instr(0, 0, 0, 0, 0, 0, 1); flush_i = 1;
      want("fl_drain", S_ST, 2);
      check();
      step(); wb(14);
      want("fl_drain_exit", S_ST, 0); want("fl_out", S_OUT, 1);
      check();
      step();
      want("fl_out_clear", S_OUT, 0);
      check();

      // spurious writeback sets sticky error
      step(); wb(12);
      want("err_before", S_ERR, 0);
      check();
      step();
      want("err_set", S_ERR, 1);
      check();
      step();
      want("err_sticky", S_ERR, 1);
      check();

      // asynchronous reset in the middle of a stall
      step(); instr(13, 0, 0, 0, 0, 1, 0);
      want("rs_issue", S_ISS, 1);
      check();
      step(); instr(0, 13, 0, 1, 0, 0, 0);
      want("rs_dep_ready", S_RDY, 0);
      check();
      step(); instr(0, 13, 0, 1, 0, 0, 0);
      want("rs_stall_state", S_ST, 1);
      check();
      rst = 1;
      want("rs_async_state", S_ST, 0); want("rs_async_out", S_OUT, 0);
      want("rs_async_err", S_ERR, 0); want("rs_async_ready", S_RDY, 1);
      check();
      step(); rst = 0; wb(13);
      want("rs_stale_wb_pre", S_ERR, 0);
      check();
      step();
      want("rs_stale_wb_err", S_ERR, 1);
      check();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/decode_scoreboard.md
Name: decode_scoreboard

Overview:
- Issue controller between the decode stage and execute.
- Tracks destination registers of in-flight instructions (issued, not yet written back) and gates decode issue on RAW/WAW hazards, in-flight capacity and fences.
- A 3-state FSM sequences normal issue, hazard stall and fence drain.
- Produces the decode-stage stall (ready) and a sticky protocol-error flag.

Parameters:
- MAX_INFLIGHT, 4, maximum outstanding register-writing instructions (1..15).
- CNT_W, 2, width of the per-register pending counter; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- id_valid_i  in  1  decode holds a valid instruction
- id_rs1_i  in  5  source register 1
- id_rs2_i  in  5  source register 2
- id_rd_i  in  5  destination register
- id_uses_rs1_i  in  1  instruction reads rs1
- id_uses_rs2_i  in  1  instruction reads rs2
- id_writes_rd_i  in  1  instruction writes rd
- id_fence_i  in  1  instruction requires drain (FENCE/ECALL)
- flush_i  in  1  kill the current decode instruction; no issue this cycle
- wb_valid_i  in  1  writeback retiring a register write
- wb_rd_i  in  5  writeback destination
- id_ready_o  out  1  issue permitted; stall = !id_ready_o
- issue_o  out  1  issue fired this cycle
- outstanding_o  out  4  registered count of in-flight writers
- state_o  out  2  FSM state
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (async, rst=1): all pending counters 0, outstanding_o=0, state_o=RUN, err_o=0. id_ready_o is combinational and reads 1 once state is RUN with zero counters.
- Register x0 is never tracked: reads of x0 never hazard; writes to x0 never increment; wb to x0 is ignored and does not set err.
- Hazard (combinational): (uses_rs1 & rs1!=0 & pend[rs1]!=0) | (uses_rs2 & rs2!=0 & pend[rs2]!=0).
- Full (combinational): outstanding_o==MAX_INFLIGHT & id_writes_rd_i & rd!=0.
- Sat (combinational): writes_rd & rd!=0 & pend[rd]==2^CNT_W-1.
- id_ready_o = (state!=DRAIN) & !hazard & !full & !sat & !(id_fence_i & outstanding_o!=0).
- issue_o = id_valid_i & id_ready_o & !flush_i.
- Counter updates take effect the next cycle; issue-to-scoreboard latency is 1.
- On issue with writes_rd & rd!=0: pend[rd]+1 and outstanding+1.
- On wb_valid_i with rd!=0: pend[wb_rd]-1 and outstanding-1.
- Issue and wb in the same cycle:
  - same rd: pend[rd] unchanged.
  - different rd: both counters update.
  - outstanding: net change only.
- wb to a register with pend==0, or with outstanding==0: no decrement, err_o<=1 (sticky until reset).
- FSM:
  - RUN -> STALL when id_valid_i & !flush_i & (hazard|full|sat).
  - RUN -> DRAIN when id_valid_i & !flush_i & id_fence_i & outstanding_o!=0.
  - STALL -> RUN when the blocking condition clears or id_valid_i drops or flush_i.
  - DRAIN -> RUN when outstanding_o==0 (registered). The fence issues in the RUN cycle that follows.
  - flush_i in DRAIN -> RUN next cycle.
  - Encoding: RUN=0, STALL=1, DRAIN=2.
- flush_i never alters the scoreboard; already-issued instructions still write back.
- rst asserted mid-operation discards all pending state immediately. Writebacks arriving after reset, for instructions issued before it, raise err_o; the pipeline is required to be flushed with reset.

Optional Feature:
- SCOREBOARD_WB_BYPASS_EN
- Defined: a writeback this cycle to a register whose pend==1 is treated as pend==0 in the hazard term, so the dependent issues in the same cycle. This models the register-file write-through path. The same applies to full: outstanding-1 when wb_valid_i & wb_rd_i!=0.
- Undefined: hazard and full use registered values only; a dependent issues one cycle after writeback.

Decomposition:
- Shared package scoreboard_pkg:
  - sb_state_e enum (RUN, STALL, DRAIN).
  - NUM_REGS=32.
  - REG_X0=5'd0.
- Opcode/funct constants stay in constants.svh.
- Sub-module sb_pending_cnt: per-register CNT_W up/down counter with inc, dec, sat and zero outputs. It is instantiated 31 times (x1..x31) via generate.

Test Plan:
- Reset, then issue add x5 (writes x5) and next cycle issue add x6,x5,x1 -> second instruction id_ready_o=0, state_o=STALL. After wb_rd_i=5, ready=1 the next cycle (same cycle with SCOREBOARD_WB_BYPASS_EN).
- Issue 4 writers to x1..x4 with MAX_INFLIGHT=4; fifth writer to x7 -> ready=0, outstanding_o=4. One wb -> ready=1, outstanding_o=3.
- Fence with outstanding_o=2 -> state_o=DRAIN, ready=0. Two wbs -> RUN, fence issues, issue_o=1.
- Same-cycle issue writing x9 and wb x9 with pend[x9]=1 -> pend stays 1, outstanding_o unchanged. Writes to x0 and reads of x0 never stall.
- wb x12 with pend[x12]=0 -> err_o=1 and stays 1. Assert rst mid-stall -> all outputs at reset values immediately, without a clock edge.
